// File: rtl/fft_stream_pkg.sv
// Shared types for the FFT spectrum serializer: bin word layout, FSM encoding and field helpers.
// The FFT_SPECTRUM_MAG_EN build uses abs_half() to form the per-bin magnitude.
package fft_stream_pkg;

    localparam int NBINS  = 16;
    localparam int BIN_W  = 32;
    localparam int HALF_W = 16;
    localparam int BIDX_W = 4;

    typedef logic [BIN_W-1:0] bin_word_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    function automatic logic signed [HALF_W-1:0] re(input bin_word_t w);
        return w[BIN_W-1:HALF_W];
    endfunction

    function automatic logic signed [HALF_W-1:0] im(input bin_word_t w);
        return w[HALF_W-1:0];
    endfunction

    // Widened by one bit first so that |-32768| = 32768 is representable.
    function automatic logic [HALF_W:0] abs_half(input logic signed [HALF_W-1:0] v);
        logic signed [HALF_W:0] x;
        x = {v[HALF_W-1], v};
        return (x < 0) ? -x : x;
    endfunction

endpackage

// File: rtl/fft_spectrum_serializer_if.sv
// Output stream bundle of the serializer. Beats follow valid/ready: a beat retires on a cycle with
// out_valid & out_ready; while out_valid & ~out_ready every payload field is held. FFT_SPECTRUM_MAG_EN adds out_mag.
interface fft_spectrum_serializer_if
    import fft_stream_pkg::*;
    #(parameter int FRAME_ID_W = 8);

    logic                  out_valid;
    logic                  out_ready;
    bin_word_t             out_data;
    logic [BIDX_W-1:0]     out_bin;
    logic                  out_last;
    logic [FRAME_ID_W-1:0] out_frame;
`ifdef FFT_SPECTRUM_MAG_EN
    logic [HALF_W:0]       out_mag;
`endif

    modport master (
        output out_valid,
        output out_data,
        output out_bin,
        output out_last,
        output out_frame,
`ifdef FFT_SPECTRUM_MAG_EN
        output out_mag,
`endif
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_bin,
        input  out_last,
        input  out_frame,
`ifdef FFT_SPECTRUM_MAG_EN
        input  out_mag,
`endif
        output out_ready
    );

endinterface

// File: rtl/frame_slot_buf.sv
// Two-slot frame store: 16 bin words plus a frame tag per slot, written whole, read one word at a time.
module frame_slot_buf
    import fft_stream_pkg::*;
    #(parameter int TAG_W = 8)
(
    input  logic              clk,
    input  logic              we,
    input  logic              wp,
    input  bin_word_t         wdata [NBINS],
    input  logic [TAG_W-1:0]  wtag,
    input  logic              rp,
    input  logic [BIDX_W-1:0] bin,
    output bin_word_t         rdata,
    output logic [TAG_W-1:0]  rtag
);

    bin_word_t        mem_q [2][NBINS];
    bin_word_t        mem_d [2][NBINS];
    logic [TAG_W-1:0] tag_q [2];
    logic [TAG_W-1:0] tag_d [2];

    always_comb begin
        mem_d = mem_q;
        tag_d = tag_q;
        if (we) begin
            for (int k = 0; k < NBINS; k++) begin
                mem_d[wp][k] = wdata[k];
            end
            tag_d[wp] = wtag;
        end
    end

    // Contents are don't-care after reset; occupancy tracking lives in the top.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        tag_q <= tag_d;
    end

    assign rdata = mem_q[rp][bin];
    assign rtag  = tag_q[rp];

endmodule

// File: rtl/fft_spectrum_serializer.sv
// Captures parallel 16-bin FFT frames into a two-slot buffer and streams them one bin per beat;
// also latches the analyzer's dominant-frequency result. FFT_SPECTRUM_MAG_EN adds out_mag = |re|+|im|.
module fft_spectrum_serializer
    import fft_stream_pkg::*;
    #(parameter int FRAME_ID_W = 8)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_valid,
    input  bin_word_t         fft_d0,
    input  bin_word_t         fft_d1,
    input  bin_word_t         fft_d2,
    input  bin_word_t         fft_d3,
    input  bin_word_t         fft_d4,
    input  bin_word_t         fft_d5,
    input  bin_word_t         fft_d6,
    input  bin_word_t         fft_d7,
    input  bin_word_t         fft_d8,
    input  bin_word_t         fft_d9,
    input  bin_word_t         fft_d10,
    input  bin_word_t         fft_d11,
    input  bin_word_t         fft_d12,
    input  bin_word_t         fft_d13,
    input  bin_word_t         fft_d14,
    input  bin_word_t         fft_d15,
    input  logic              done,
    input  logic [BIDX_W-1:0] freq,
    fft_spectrum_serializer_if.master strm,
    output logic              ovf,
    output logic              res_valid,
    output logic [BIDX_W-1:0] res_freq,
    output state_t            dbg_state
);

    state_t                state_q, state_d;
    logic [1:0]            count_q, count_d;
    logic                  wp_q, wp_d;
    logic                  rp_q, rp_d;
    logic [BIDX_W-1:0]     bin_q, bin_d;
    logic [FRAME_ID_W-1:0] fid_q, fid_d;
    logic                  ovf_q, ovf_d;
    logic                  res_valid_q, res_valid_d;
    logic [BIDX_W-1:0]     res_freq_q, res_freq_d;

    logic                  streaming, beat, pop, cap;
    bin_word_t             fft_words [NBINS];
    bin_word_t             rd_word, data_o;
    logic [FRAME_ID_W-1:0] rd_tag;

    assign fft_words = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                         fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

    frame_slot_buf #(.TAG_W(FRAME_ID_W)) u_buf (
        .clk   (clk),
        .we    (cap),
        .wp    (wp_q),
        .wdata (fft_words),
        .wtag  (fid_q),
        .rp    (rp_q),
        .bin   (bin_q),
        .rdata (rd_word),
        .rtag  (rd_tag)
    );

    // A full buffer still accepts a frame when its head frame retires on the same edge.
    always_comb begin
        streaming   = (state_q == ST_STREAM);
        beat        = streaming & strm.out_ready;
        pop         = beat & (bin_q == BIDX_W'(NBINS - 1));
        cap         = fft_valid & ((count_q != 2'd2) | pop);

        count_d     = count_q + {1'b0, cap} - {1'b0, pop};
        wp_d        = wp_q ^ cap;
        rp_d        = rp_q ^ pop;
        bin_d       = beat ? bin_q + 1'b1 : bin_q;
        fid_d       = fid_q + {{(FRAME_ID_W-1){1'b0}}, fft_valid};
        ovf_d       = ovf_q | (fft_valid & ~cap);
        res_valid_d = res_valid_q | done;
        res_freq_d  = done ? freq : res_freq_q;
        state_d     = (count_d != 2'd0) ? ST_STREAM : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            count_q     <= 2'd0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            bin_q       <= '0;
            fid_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_freq_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            bin_q       <= bin_d;
            fid_q       <= fid_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            res_freq_q  <= res_freq_d;
        end
    end

    // Payload is forced to zero outside STREAM so idle and reset outputs read as 0.
    assign data_o         = streaming ? rd_word : '0;
    assign strm.out_valid = streaming;
    assign strm.out_data  = data_o;
    assign strm.out_bin   = bin_q;
    assign strm.out_last  = streaming & (bin_q == BIDX_W'(NBINS - 1));
    assign strm.out_frame = streaming ? rd_tag : '0;
`ifdef FFT_SPECTRUM_MAG_EN
    assign strm.out_mag   = abs_half(re(data_o)) + abs_half(im(data_o));
`endif

    assign ovf       = ovf_q;
    assign res_valid = res_valid_q;
    assign res_freq  = res_freq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_spectrum_serializer.sv
// Directed self-checking bench for fft_spectrum_serializer; each stream beat is checked against a queue of hand-built expectations.
module tb_fft_spectrum_serializer;
    import fft_stream_pkg::*;

    localparam int FID_W = 8;
    localparam int TUP_W = 1 + FID_W + BIDX_W + 1 + BIN_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fft_valid = 1'b0;
    bin_word_t         fft_d [NBINS];
    logic              done = 1'b0;
    logic [BIDX_W-1:0] freq = '0;
    logic              ovf;
    logic              res_valid;
    logic [BIDX_W-1:0] res_freq;
    state_t            dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int first_hs = 0;
    int last_hs = 0;

    logic [TUP_W-1:0] exp_q[$];
    logic             prev_stall = 1'b0;
    logic [TUP_W-1:0] prev_obs;

    fft_spectrum_serializer_if #(.FRAME_ID_W(FID_W)) strm();

    fft_spectrum_serializer #(.FRAME_ID_W(FID_W)) dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(fft_d[0]),   .fft_d1(fft_d[1]),   .fft_d2(fft_d[2]),   .fft_d3(fft_d[3]),
        .fft_d4(fft_d[4]),   .fft_d5(fft_d[5]),   .fft_d6(fft_d[6]),   .fft_d7(fft_d[7]),
        .fft_d8(fft_d[8]),   .fft_d9(fft_d[9]),   .fft_d10(fft_d[10]), .fft_d11(fft_d[11]),
        .fft_d12(fft_d[12]), .fft_d13(fft_d[13]), .fft_d14(fft_d[14]), .fft_d15(fft_d[15]),
        .done(done), .freq(freq), .strm(strm),
        .ovf(ovf), .res_valid(res_valid), .res_freq(res_freq), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [TUP_W-1:0] obs();
        return {strm.out_valid, strm.out_frame, strm.out_bin, strm.out_last, strm.out_data};
    endfunction

    // scoreboard: handshakes are sampled mid-cycle, ahead of the edge that retires them
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold", obs(), prev_obs);
            if (strm.out_valid && strm.out_ready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("beat", obs(), exp_q.pop_front());
                if (hs_count == 0) first_hs = cyc;
                last_hs = cyc;
                hs_count++;
            end
            prev_stall = strm.out_valid && !strm.out_ready;
            prev_obs   = obs();
        end
    end

    // driver tasks
    task automatic fill(input int base);
        for (int k = 0; k < NBINS; k++) begin
            fft_d[k] = {16'(base + k), 16'(-(base + k))};
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        fft_valid = 1'b0;
        done      = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send_frame(input logic push, input logic [FID_W-1:0] tag);
        fft_valid = 1'b1;
        if (push) begin
            for (int k = 0; k < NBINS; k++) begin
                exp_q.push_back({1'b1, tag, 4'(k), (k == NBINS - 1), fft_d[k]});
            end
        end
        @(posedge clk);
        #1 fft_valid = 1'b0;
    endtask

    task automatic drain(input bit bp, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            strm.out_ready = bp ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check("drained", exp_q.size(), 0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        strm.out_ready = 1'b0;
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", strm.out_valid, 0);
        check("rst_data", strm.out_data, 0);
        check("rst_bin", strm.out_bin, 0);
        check("rst_last", strm.out_last, 0);
        check("rst_frame", strm.out_frame, 0);
        check("rst_ovf", ovf, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_freq", res_freq, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        idle_cycle();

        // single frame, d_k = {k, -k}, no backpressure
        strm.out_ready = 1'b1;
        fill(0);
        hs_count = 0;
        send_frame(1'b1, 8'd0);
        check("t1_latency_valid", strm.out_valid, 1);
        check("t1_first_bin", strm.out_bin, 0);
        check("t1_first_data", strm.out_data, 32'h0000_0000);
        check("t1_state", dbg_state, ST_STREAM);
        drain(1'b0, 40);
        check("t1_idle", strm.out_valid, 0);
        check("t1_beats", hs_count, 16);
        check("t1_gapless", last_hs - first_hs, 15);
        check("t1_ovf", ovf, 0);

        // backpressure 1,0,0,1,...
        fill(500);
        hs_count = 0;
        send_frame(1'b1, 8'd1);
        drain(1'b1, 100);
        check("t2_idle", strm.out_valid, 0);
        check("t2_beats", hs_count, 16);
        check("t2_ovf", ovf, 0);

        // three frames while stalled: third dropped, id counter still advances
        do_reset();
        strm.out_ready = 1'b0;
        hs_count = 0;
        fill(1000);
        send_frame(1'b1, 8'd0);
        idle_cycle();
        fill(2000);
        send_frame(1'b1, 8'd1);
        idle_cycle();
        fill(3000);
        send_frame(1'b0, 8'd2);
        check("t3_ovf", ovf, 1);
        check("t3_state", dbg_state, ST_STREAM);
        check("t3_head_frame", strm.out_frame, 0);
        drain(1'b0, 80);
        check("t3_beats", hs_count, 32);
        check("t3_idle", strm.out_valid, 0);
        fill(4000);
        send_frame(1'b1, 8'd3);
        drain(1'b0, 40);
        check("t3_ovf_sticky", ovf, 1);

        // full buffer, new frame exactly on the head frame's last handshake
        do_reset();
        check("t4_ovf_cleared", ovf, 0);
        strm.out_ready = 1'b0;
        fill(100);
        send_frame(1'b1, 8'd0);
        idle_cycle();
        fill(200);
        send_frame(1'b1, 8'd1);
        hs_count = 0;
        strm.out_ready = 1'b1;
        for (int i = 0; i < 40 && !(strm.out_valid && strm.out_last); i++) idle_cycle();
        check("t4_at_last", strm.out_last, 1);
        check("t4_at_last_frame", strm.out_frame, 0);
        fill(300);
        send_frame(1'b1, 8'd2);
        check("t4_no_ovf", ovf, 0);
        drain(1'b0, 80);
        check("t4_beats", hs_count, 48);
        check("t4_gapless", last_hs - first_hs, 47);
        check("t4_idle", strm.out_valid, 0);

        // reset in the middle of a frame
        do_reset();
        strm.out_ready = 1'b1;
        fill(7);
        send_frame(1'b1, 8'd0);
        for (int i = 0; i < 40 && strm.out_bin != 4'd7; i++) idle_cycle();
        check("t5_at_bin7", strm.out_bin, 7);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_valid", strm.out_valid, 0);
        check("t5_rst_data", strm.out_data, 0);
        check("t5_rst_bin", strm.out_bin, 0);
        check("t5_rst_state", dbg_state, ST_IDLE);
        @(posedge clk);
        #1 rst = 1'b1;
        idle_cycle();
        fill(9000);
        hs_count = 0;
        send_frame(1'b1, 8'd0);
        check("t5_restart_bin", strm.out_bin, 0);
        check("t5_restart_frame", strm.out_frame, 0);
        drain(1'b0, 40);
        check("t5_beats", hs_count, 16);

        // analyzer result latch
        done = 1'b1;
        freq = 4'd5;
        idle_cycle();
        done = 1'b0;
        freq = 4'd2;
        check("t6_res_valid", res_valid, 1);
        check("t6_res_freq5", res_freq, 5);
        done = 1'b1;
        freq = 4'd9;
        idle_cycle();
        done = 1'b0;
        freq = 4'd3;
        check("t6_res_freq9", res_freq, 9);
        idle_cycle();
        check("t6_res_hold", res_freq, 9);
        check("t6_res_valid_hold", res_valid, 1);

`ifdef FFT_SPECTRUM_MAG_EN
        strm.out_ready = 1'b0;
        fill(0);
        fft_d[0] = {16'h8000, 16'd100};
        fft_d[1] = {16'hFFFF, 16'h0001};
        send_frame(1'b1, 8'd1);
        check("mag_min_real", strm.out_mag, 32868);
        strm.out_ready = 1'b1;
        idle_cycle();
        check("mag_small", strm.out_mag, 2);
        drain(1'b0, 40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
